// File: rtl/fetch_unit.sv
// Instruction-fetch front end: a req/rvalid memory handshake, instruction hold until retire, and next-PC select.
// Optional macro FETCH_ALIGN_CHECK_EN traps a misaligned next PC into a halt state.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] ins,
  output logic        ins_valid,
  input  logic        ins_ready,
  input  logic        pc_src,
  input  logic [31:0] imm_ext,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] pc_target,
  output logic        fetch_err
);

  localparam int unsigned XLEN = 32;

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;
`endif

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   ins_q, ins_d;
  logic              ins_valid_q, ins_valid_d;
  logic              imem_req_q, imem_req_d;
  logic              fetch_err_q, fetch_err_d;
  logic [XLEN-1:0]   next_pc;

  // PC arithmetic wraps modulo 2^32 by construction of the 32-bit sums.
  assign pc_plus4  = pc_q + XLEN'(4);
  assign pc_target = pc_q + imm_ext;
  assign next_pc   = pc_src ? pc_target : pc_plus4;

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign imem_req  = imem_req_q;
  assign ins       = ins_q;
  assign ins_valid = ins_valid_q;
  assign fetch_err = fetch_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      ins_q       <= NOP_INS;
      ins_valid_q <= 1'b0;
      imem_req_q  <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ins_q       <= ins_d;
      ins_valid_q <= ins_valid_d;
      imem_req_q  <= imem_req_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // Next-state and registered-output logic; rvalid/ready outside their own states are ignored.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ins_d       = ins_q;
    ins_valid_d = ins_valid_q;
    imem_req_d  = imem_req_q;
    fetch_err_d = fetch_err_q;
    case (state_q)
      S_IDLE: begin
        state_d    = S_FETCH;
        imem_req_d = 1'b1;
      end
      S_FETCH: begin
        if (imem_rvalid) begin
          ins_d       = imem_rdata;
          ins_valid_d = 1'b1;
          imem_req_d  = 1'b0;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (ins_ready) begin
          ins_d       = NOP_INS;
          ins_valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
          if (next_pc[1:0] != 2'b00) begin
            fetch_err_d = 1'b1;
            state_d     = S_HALT;
          end else begin
            pc_d       = next_pc;
            imem_req_d = 1'b1;
            state_d    = S_FETCH;
          end
`else
          pc_d       = next_pc;
          imem_req_d = 1'b1;
          state_d    = S_FETCH;
`endif
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      S_HALT: begin
        imem_req_d  = 1'b0;
        ins_valid_d = 1'b0;
        ins_d       = NOP_INS;
      end
`endif
      default: begin
        state_d     = S_IDLE;
        imem_req_d  = 1'b0;
        ins_valid_d = 1'b0;
        ins_d       = NOP_INS;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, random traffic against a PC/instruction model, corner sequences.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic [31:0] ins;
  logic        ins_valid;
  logic        ins_ready;
  logic        pc_src;
  logic [31:0] imm_ext;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_target;
  logic        fetch_err;

  fetch_unit #(.RESET_PC(RST_PC), .NOP_INS(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
    .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .pc_src(pc_src), .imm_ext(imm_ext),
    .pc(pc), .pc_plus4(pc_plus4), .pc_target(pc_target), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_ins;

  typedef struct {
    int unsigned lat;
    logic [31:0] data;
    logic        src;
    logic [31:0] imm;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Retire the held instruction; the model picks the next PC from the branch rule.
  task automatic retire(input logic src, input logic [31:0] imm, input logic [31:0] exp_next);
    pc_src    = src;
    imm_ext   = imm;
    ins_ready = 1'b1;
    #1;
    chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
    chk("pc_target", pc_target, exp_pc + imm);
    tick();
    ins_ready = 1'b0;
    pc_src    = 1'($urandom);
    imm_ext   = $urandom;
    exp_pc    = exp_next;
    chk("retire_pc", pc, exp_pc);
    chk("retire_addr", imem_addr, exp_pc);
    chk("retire_req", 32'(imem_req), 32'd1);
    chk("retire_valid", 32'(ins_valid), 32'd0);
    chk("retire_ins_nop", ins, NOP);
  endtask

  // Memory answers after lat wait cycles; request/address must stay stable meanwhile.
  task automatic fetch(input int unsigned lat, input logic [31:0] data, input bit junk_ready);
    for (int i = 0; i < int'(lat); i++) begin
      if (junk_ready) ins_ready = 1'($urandom);
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, exp_pc);
      chk("wait_valid", 32'(ins_valid), 32'd0);
      tick();
    end
    ins_ready = 1'b0;
    chk("resp_req", 32'(imem_req), 32'd1);
    chk("resp_addr", imem_addr, exp_pc);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    exp_ins     = data;
    chk("cap_ins", ins, exp_ins);
    chk("cap_valid", 32'(ins_valid), 32'd1);
    chk("cap_req", 32'(imem_req), 32'd0);
  endtask

  // Stall with ins_ready low; optional stray rvalid pulses must be ignored.
  task automatic hold(input int unsigned n, input bit noise);
    for (int i = 0; i < int'(n); i++) begin
      imem_rvalid = noise ? 1'($urandom) : 1'b0;
      imem_rdata  = $urandom;
      tick();
      chk("hold_ins", ins, exp_ins);
      chk("hold_valid", 32'(ins_valid), 32'd1);
      chk("hold_pc", pc, exp_pc);
      chk("hold_req", 32'(imem_req), 32'd0);
      chk("hold_err", 32'(fetch_err), 32'd0);
    end
    imem_rvalid = 1'b0;
  endtask

  initial begin
    logic        src;
    logic [31:0] imm;
    logic [31:0] nxt;

    vecs[0] = '{0, 32'h0010_0113, 1'b0, 32'h0000_0000, 32'h0000_0104};
    vecs[1] = '{3, 32'h0020_0193, 1'b1, 32'hFFFF_FFF8, 32'h0000_00FC};
    vecs[2] = '{1, 32'h0030_0213, 1'b1, 32'h0000_0104, 32'h0000_0200};
    vecs[3] = '{0, 32'h0040_0293, 1'b1, 32'hFFFF_FFF8, 32'h0000_01F8};
    vecs[4] = '{2, 32'h0050_0313, 1'b1, 32'h0000_0008, 32'h0000_0200};
    vecs[5] = '{0, 32'h0060_0393, 1'b0, 32'hFFFF_FFF8, 32'h0000_0204};
    vecs[6] = '{0, 32'h0070_0413, 1'b1, 32'hFFFF_FDF8, 32'hFFFF_FFFC};
    vecs[7] = '{1, 32'h0080_0493, 1'b0, 32'h0000_0000, 32'h0000_0000};

    rst_n = 1'b1; imem_rdata = '0; imem_rvalid = 1'b0; ins_ready = 1'b0; pc_src = 1'b0; imm_ext = '0;
    #1 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_pc", pc, RST_PC);
    chk("rst_ins", ins, NOP);
    chk("rst_valid", 32'(ins_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);

    // One idle cycle after release, then a zero-wait fetch at RESET_PC.
    rst_n = 1'b1;
    #1;
    chk("idle_req", 32'(imem_req), 32'd0);
    tick();
    exp_pc = RST_PC;
    fetch(0, 32'h0050_0093, 1'b0);
    hold(10, 1'b0);

    foreach (vecs[i]) begin
      retire(vecs[i].src, vecs[i].imm, vecs[i].exp_pc);
      fetch(vecs[i].lat, vecs[i].data, 1'b1);
      hold(2, 1'b1);
    end

    for (int k = 0; k < 40; k++) begin
      src = 1'($urandom);
      imm = $urandom & 32'hFFFF_FFFC;
      nxt = src ? exp_pc + imm : exp_pc + 32'd4;
      retire(src, imm, nxt);
      fetch($urandom_range(0, 3), $urandom, 1'b1);
      hold($urandom_range(0, 3), 1'b1);
    end

    // Reset while waiting for memory: immediate reset values, late response dropped.
    retire(1'b0, 32'h0, exp_pc + 32'd4);
    chk("mid_req", 32'(imem_req), 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, RST_PC);
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_valid", 32'(ins_valid), 32'd0);
    chk("arst_ins", ins, NOP);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    rst_n = 1'b1;
    tick();
    imem_rvalid = 1'b0;
    chk("late_ins", ins, NOP);
    chk("late_valid", 32'(ins_valid), 32'd0);
    chk("restart_req", 32'(imem_req), 32'd1);
    chk("restart_addr", imem_addr, RST_PC);
    exp_pc = RST_PC;
    fetch(2, 32'h00A0_0513, 1'b0);
    hold(1, 1'b0);

    // Misaligned branch target.
`ifdef FETCH_ALIGN_CHECK_EN
    pc_src = 1'b1; imm_ext = 32'h6; ins_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("halt_err", 32'(fetch_err), 32'd1);
      chk("halt_pc", pc, exp_pc);
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_valid", 32'(ins_valid), 32'd0);
      chk("halt_ins", ins, NOP);
      imem_rvalid = 1'b1;
      tick();
    end
    imem_rvalid = 1'b0; ins_ready = 1'b0;
`else
    retire(1'b1, 32'h6, exp_pc + 32'h6);
    chk("mis_err", 32'(fetch_err), 32'd0);
    fetch(0, 32'h00B0_0593, 1'b0);
    hold(1, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end that produces the 32-bit instruction word `ins` consumed by `control_unit`.
- Consumes `control_unit`'s `pc_src` and the datapath's sign-extended immediate to select the next PC.
- Talks to instruction memory over a req/rvalid handshake, so memory may take a variable number of cycles.
- Holds each instruction stable for decode/execute until the execute side signals it is done.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INS, 32'h0000_0013, value driven on `ins` when no valid instruction is held (addi x0,x0,0).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; always equals pc.
- imem_rdata  input  32  instruction word from memory; sampled when imem_rvalid=1.
- imem_rvalid  input  1  memory response valid.
- ins  output  32  instruction to `control_unit` and datapath.
- ins_valid  output  1  `ins` holds a fetched instruction.
- ins_ready  input  1  execute side has completed the current instruction this cycle.
- pc_src  input  1  from `control_unit`; 1 selects the branch/jump target.
- imm_ext  input  32  sign-extended immediate, already shifted as per the ISA.
- pc  output  32  address of the current instruction.
- pc_plus4  output  32  pc+4, combinational (JAL link value).
- pc_target  output  32  pc+imm_ext, combinational.
- fetch_err  output  1  misaligned-target trap flag; only present with FETCH_ALIGN_CHECK_EN, otherwise tied 0.

Behaviour:
- Reset (rst_n=0, asynchronous) drives:
  - pc=RESET_PC, ins=NOP_INS, ins_valid=0, imem_req=0, fetch_err=0, state=S_IDLE.
  - Reset asserted mid-fetch abandons the transaction; any later imem_rvalid is ignored until S_FETCH is re-entered.
- States: S_IDLE, S_FETCH, S_HOLD, S_HALT (S_HALT exists only with the optional feature).
- S_IDLE: entered for exactly one cycle after reset release; unconditionally moves to S_FETCH.
- S_FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until the response arrives.
  - imem_rvalid may rise in the same cycle as imem_req (zero-wait memory) or any number of cycles later.
  - On the edge where imem_rvalid=1: ins<=imem_rdata, ins_valid<=1, go to S_HOLD.
- S_HOLD:
  - imem_req=0; ins, ins_valid and pc are stable.
  - On the edge where ins_ready=1: pc<=(pc_src ? pc_target : pc_plus4), ins_valid<=0, ins<=NOP_INS, go to S_FETCH.
  - pc_src and imm_ext are sampled only on that edge.
- imem_rvalid in any state other than S_FETCH is ignored.
- ins_ready outside S_HOLD is ignored.
- Throughput: one instruction per 2 cycles at best (zero-wait memory, ins_ready high); each memory wait cycle adds one.
- Arithmetic: all PC sums are 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- ins_valid=0 implies ins=NOP_INS, so `control_unit` never sees stale opcodes.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined: at the S_HOLD retire edge, if the selected next PC has [1:0]!=2'b00:
  - pc is not updated; fetch_err<=1; state goes to S_HALT.
  - S_HALT: imem_req=0, ins_valid=0, ins=NOP_INS; it is left only by reset.
- Undefined:
  - fetch_err is constant 0.
  - Misaligned targets are loaded into pc and fetched as-is.
  - S_HALT does not exist.

Test Plan:
- Reset with RESET_PC=32'h100, release rst_n, memory answers in the same cycle with 32'h00500093 -> imem_req rises 1 cycle after release with imem_addr=32'h100; ins=32'h00500093 and ins_valid=1 on the next edge.
- Memory latency 3 cycles -> imem_req held 4 cycles at a constant imem_addr; ins_valid rises exactly once; rvalid pulses injected during S_HOLD change nothing.
- In S_HOLD: pc=32'h200, pc_src=1, imm_ext=32'hFFFF_FFF8, ins_ready=1 -> next imem_addr=32'h1F8. Repeat with pc_src=0 -> 32'h204. pc_plus4 reads 32'h204 while pc=32'h200.
- ins_ready held low for 10 cycles -> ins and pc unchanged, no new imem_req; one ins_ready pulse retires exactly one instruction.
- rst_n asserted while in S_FETCH awaiting memory -> outputs take reset values immediately (asynchronously); a late imem_rvalid is not captured; fetch restarts at RESET_PC.
- With FETCH_ALIGN_CHECK_EN: pc=32'h300, pc_src=1, imm_ext=32'h6 -> fetch_err=1, pc stays 32'h300, imem_req remains 0 until reset.
